// File: rtl/slope_adc_ctrl.sv
// rtl/slope_adc_ctrl.sv - single-slope ADC sequencer: discharge, ramp, count to comparator trip, hand off result
module slope_adc_ctrl #(
  parameter int CNT_W            = 10,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int CONTINUOUS       = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic             comp_in,
  output logic             ramp_en,
  output logic             discharge,
  output logic             busy,
  output logic [CNT_W-1:0] sample,
  output logic             sample_overrange,
  output logic             sample_valid,
  input  logic             sample_ready
);

  localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [DW-1:0]    DISCH_LAST = DW'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, DISCH, RAMP, HOLD} state_t;

  state_t           state_q;
  logic             comp_m_q;
  logic             comp_s_q;
  logic [DW-1:0]    disch_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] res_q;
  logic             ovr_q;
  logic             ramp_en_q;
  logic             discharge_q;
  logic             busy_q;
  logic [CNT_W-1:0] sample_q;
  logic             sample_ovr_q;
  logic             sample_valid_q;

  // comp_in is asynchronous to clk; only comp_s_q is used downstream
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      comp_m_q <= 1'b0;
      comp_s_q <= 1'b0;
    end else begin
      comp_m_q <= comp_in;
      comp_s_q <= comp_m_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= IDLE;
      disch_cnt_q    <= '0;
      cnt_q          <= '0;
      res_q          <= '0;
      ovr_q          <= 1'b0;
      ramp_en_q      <= 1'b0;
      discharge_q    <= 1'b0;
      busy_q         <= 1'b0;
      sample_q       <= '0;
      sample_ovr_q   <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      // Consumer handshake; a HOLD reload below overrides this in the same edge
      if (sample_valid_q && sample_ready) begin
        sample_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start || (CONTINUOUS != 0)) begin
            state_q     <= DISCH;
            discharge_q <= 1'b1;
            busy_q      <= 1'b1;
            disch_cnt_q <= '0;
          end
        end
        DISCH: begin
          if (disch_cnt_q == DISCH_LAST) begin
            state_q     <= RAMP;
            discharge_q <= 1'b0;
            ramp_en_q   <= 1'b1;
            cnt_q       <= '0;
          end else begin
            disch_cnt_q <= disch_cnt_q + 1'b1;
          end
        end
        RAMP: begin
          // A trip on the full-scale cycle wins over overrange
          if (comp_s_q) begin
            res_q     <= cnt_q;
            ovr_q     <= 1'b0;
            ramp_en_q <= 1'b0;
            state_q   <= HOLD;
          end else if (cnt_q == CNT_MAX) begin
            res_q     <= CNT_MAX;
            ovr_q     <= 1'b1;
            ramp_en_q <= 1'b0;
            state_q   <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (!sample_valid_q || sample_ready) begin
            sample_q       <= res_q;
            sample_ovr_q   <= ovr_q;
            sample_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ramp_en          = ramp_en_q;
  assign discharge        = discharge_q;
  assign busy             = busy_q;
  assign sample           = sample_q;
  assign sample_overrange = sample_ovr_q;
  assign sample_valid     = sample_valid_q;

endmodule

// File: tb/tb_slope_adc_ctrl.sv
// tb/tb_slope_adc_ctrl.sv - directed bench for slope_adc_ctrl (single-shot and continuous instances)
module tb_slope_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_l, start, comp_in, sample_ready;
  logic       ramp_en, discharge, busy, sample_overrange, sample_valid;
  logic [9:0] sample;

  logic       rst_c, comp_c, ready_c;
  logic       ramp_en_c, discharge_c, busy_c, ovr_c, valid_c;
  logic [9:0] sample_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slope_adc_ctrl #(.CNT_W(10), .DISCHARGE_CYCLES(4), .CONTINUOUS(0)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .comp_in(comp_in),
    .ramp_en(ramp_en), .discharge(discharge), .busy(busy),
    .sample(sample), .sample_overrange(sample_overrange),
    .sample_valid(sample_valid), .sample_ready(sample_ready)
  );

  slope_adc_ctrl #(.CNT_W(10), .DISCHARGE_CYCLES(4), .CONTINUOUS(1)) dut_c (
    .clk(clk), .rst_l(rst_c), .start(1'b0), .comp_in(comp_c),
    .ramp_en(ramp_en_c), .discharge(discharge_c), .busy(busy_c),
    .sample(sample_c), .sample_overrange(ovr_c),
    .sample_valid(valid_c), .sample_ready(ready_c)
  );

  // trip < 0: never trip; trip >= 0: comp_in high during ramp cycle 'trip'
  task automatic run_conv(input int trip, output int disch_n, output int ramp_n, output int overlap);
    int guard;
    disch_n = 0; ramp_n = 0; overlap = 0; guard = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!ramp_en && guard < 100) begin
      if (discharge) disch_n++;
      @(posedge clk); #1;
      guard++;
    end
    while (ramp_en && guard < 3000) begin
      if (discharge) overlap++;
      if (ramp_n == trip) comp_in = 1'b1;
      ramp_n++;
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
    comp_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; start = 1'b0; comp_in = 1'b1; sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ramp_en, discharge, busy, sample, sample_overrange, sample_valid} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {ramp_en, discharge, busy, sample, sample_overrange, sample_valid});
    end
    comp_in = 1'b0;
    rst_l = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || discharge !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start busy=%b discharge=%b exp=0,0", busy, discharge);
    end
  endtask

  task automatic test_nominal();
    int d, r, o;
    run_conv(100, d, r, o);
    checks++;
    if (d !== 4) begin failures++; $display("FAIL nominal_discharge_cycles got=%0d exp=4", d); end
    checks++;
    if (r !== 103) begin failures++; $display("FAIL nominal_ramp_cycles got=%0d exp=103", r); end
    checks++;
    if (o !== 0) begin failures++; $display("FAIL nominal_overlap got=%0d exp=0", o); end
    checks++;
    if (sample !== 10'd102 || sample_overrange !== 1'b0 || sample_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nominal_result sample=%0d ovr=%b valid=%b busy=%b exp=102,0,1,0", sample, sample_overrange, sample_valid, busy);
    end
    consume();
    checks++;
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL nominal_consume valid=%b exp=0", sample_valid); end
  endtask

  task automatic test_overrange();
    int d, r, o;
    run_conv(-1, d, r, o);
    checks++;
    if (r !== 1024) begin failures++; $display("FAIL ovr_ramp_cycles got=%0d exp=1024", r); end
    checks++;
    if (sample !== 10'd1023 || sample_overrange !== 1'b1 || sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_result sample=%0d ovr=%b valid=%b exp=1023,1,1", sample, sample_overrange, sample_valid);
    end
    consume();
  endtask

  task automatic test_immediate_trip();
    int d, r, o;
    comp_in = 1'b1;
    run_conv(-1, d, r, o);
    checks++;
    if (r !== 1 || sample !== 10'd0 || sample_overrange !== 1'b0 || sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL immediate_trip ramp=%0d sample=%0d ovr=%b valid=%b exp=1,0,0,1", r, sample, sample_overrange, sample_valid);
    end
    consume();
    run_conv(1021, d, r, o);
    checks++;
    if (r !== 1024 || sample !== 10'd1023 || sample_overrange !== 1'b0) begin
      failures++;
      $display("FAIL fullscale_trip ramp=%0d sample=%0d ovr=%b exp=1024,1023,0", r, sample, sample_overrange);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int guard, n;
    comp_c = 1'b0; ready_c = 1'b0; rst_c = 1'b1;
    for (int conv = 0; conv < 2; conv++) begin
      guard = 0; n = 0;
      while (!ramp_en_c && guard < 100) begin @(posedge clk); #1; guard++; end
      while (ramp_en_c && guard < 3000) begin
        if (n == ((conv == 0) ? 10 : 20)) comp_c = 1'b1;
        n++;
        @(posedge clk); #1;
        guard++;
      end
      comp_c = 1'b0;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sample_c !== 10'd12 || ovr_c !== 1'b0 || valid_c !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_held sample=%0d ovr=%b valid=%b exp=12,0,1", sample_c, ovr_c, valid_c);
    end
    checks++;
    if (busy_c !== 1'b1 || ramp_en_c !== 1'b0 || discharge_c !== 1'b0) begin
      failures++;
      $display("FAIL bp_parked_hold busy=%b ramp=%b disch=%b exp=1,0,0", busy_c, ramp_en_c, discharge_c);
    end
    ready_c = 1'b1;
    @(posedge clk); #1;
    ready_c = 1'b0;
    checks++;
    if (sample_c !== 10'd22 || valid_c !== 1'b1) begin
      failures++;
      $display("FAIL bp_replace sample=%0d valid=%b exp=22,1", sample_c, valid_c);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample_c !== 10'd22 || valid_c !== 1'b1 || busy_c !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_stable sample=%0d valid=%b busy=%b exp=22,1,1", sample_c, valid_c, busy_c);
    end
    ready_c = 1'b1;
    @(posedge clk); #1;
    ready_c = 1'b0;
    checks++;
    if (valid_c !== 1'b0) begin failures++; $display("FAIL bp_no_duplicate valid=%b exp=0", valid_c); end
    rst_c = 1'b0;
  endtask

  task automatic test_async_abort();
    int guard, d, r, o;
    guard = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!ramp_en && guard < 100) begin @(posedge clk); #1; guard++; end
    repeat (7) @(posedge clk);
    #3;
    checks++;
    if (ramp_en !== 1'b1) begin failures++; $display("FAIL abort_precondition ramp=%b exp=1", ramp_en); end
    rst_l = 1'b0;
    #1;
    checks++;
    if (ramp_en !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_async ramp=%b busy=%b valid=%b exp=0,0,0", ramp_en, busy, sample_valid);
    end
    #12;
    rst_l = 1'b1;
    run_conv(50, d, r, o);
    checks++;
    if (d !== 4 || r !== 53 || sample !== 10'd52 || sample_overrange !== 1'b0 || sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_recover disch=%0d ramp=%0d sample=%0d ovr=%b valid=%b exp=4,53,52,0,1", d, r, sample, sample_overrange, sample_valid);
    end
    consume();
  endtask

  initial begin
    rst_c = 1'b0; comp_c = 1'b0; ready_c = 1'b0;
    test_reset();
    test_nominal();
    test_overrange();
    test_immediate_trip();
    test_back_to_back();
    test_async_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
